// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared widths, FSM state type and saturating log-domain subtract helper
package softmax_pkg;

    localparam int DEF_NUM_INPUTS = 10;
    localparam int DEF_LANES      = 2;
    localparam int DEF_MANT_WIDTH = 8;
    localparam int DEF_EXP_WIDTH  = 9;
    localparam int SAT_W          = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sub_state_t;

    // Returns {sat, result}; the caller keeps the low exp_w bits of result.
    function automatic logic [SAT_W:0] sat_sub(
        input logic [SAT_W-1:0] x,
        input logic [SAT_W-1:0] s,
        input int               exp_w,
        input logic             saturate
    );
        longint d;
        longint hi;
        longint lo;
        logic   sat;
        d   = $signed({32'b0, x}) - $signed({32'b0, s});
        hi  = (longint'(1) <<< (exp_w - 1)) - 1;
        lo  = -hi - 1;
        sat = 1'b0;
        if (saturate && d > hi) begin
            d   = hi;
            sat = 1'b1;
        end else if (saturate && d < lo) begin
            d   = lo;
            sat = 1'b1;
        end
        return {sat, d[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/subtractor_lane.sv
// rtl/subtractor_lane.sv - one combinational lane computing x - exp_sum with optional clamp
module subtractor_lane
    import softmax_pkg::*;
#(
    parameter int MANT_WIDTH = DEF_MANT_WIDTH,
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int SATURATE   = 1
) (
    input  logic [MANT_WIDTH-1:0] x,
    input  logic [EXP_WIDTH-1:0]  s,
    output logic [EXP_WIDTH-1:0]  result,
    output logic                  sat
);

    logic [SAT_W:0] r;
    logic           unused_hi;

    assign r         = sat_sub(SAT_W'(x), SAT_W'(s), EXP_WIDTH, SATURATE != 0);
    assign result    = r[EXP_WIDTH-1:0];
    assign sat       = r[SAT_W];
    assign unused_hi = ^r[SAT_W-1:EXP_WIDTH];

endmodule

// File: rtl/subtractors_pipe.sv
// rtl/subtractors_pipe.sv - beat-serial log-domain subtractor array with valid/ready output stream
module subtractors_pipe
    import softmax_pkg::*;
#(
    parameter int  NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int  LANES      = DEF_LANES,
    parameter int  MANT_WIDTH = DEF_MANT_WIDTH,
    parameter int  EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int  SATURATE   = 1,
    localparam int NUM_BEATS  = NUM_INPUTS / LANES,
    localparam int IDX_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [EXP_WIDTH-1:0]             exp_sum,
    input  logic [NUM_INPUTS*MANT_WIDTH-1:0] input_bus,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*EXP_WIDTH-1:0]       out_data,
    output logic [LANES-1:0]                 out_sat,
    output logic [IDX_W-1:0]                 out_beat,
    output logic                             out_last
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_BEATS - 1);

    if (NUM_INPUTS % LANES != 0) begin : g_bad_lanes
        $error("NUM_INPUTS must be a multiple of LANES");
    end
    if (EXP_WIDTH < 2 || EXP_WIDTH >= SAT_W || MANT_WIDTH > SAT_W) begin : g_bad_width
        $error("unsupported MANT_WIDTH/EXP_WIDTH");
    end

    sub_state_t                      state;
    logic [NUM_INPUTS*MANT_WIDTH-1:0] vec_q;
    logic [EXP_WIDTH-1:0]            sum_q;
    logic [IDX_W-1:0]                next_beat;
    logic                            advance;
    logic                            last_taken;
    logic [LANES*EXP_WIDTH-1:0]      lane_data;
    logic [LANES-1:0]                lane_sat;

    assign in_ready   = (state == ST_IDLE) && !rst;
    assign advance    = !out_valid || out_ready;
    assign last_taken = out_valid && out_ready && out_last;
    // The output register itself is the beat counter: the next beat follows the one on display.
    assign next_beat  = (out_valid && out_beat != LAST_BEAT) ? out_beat + IDX_W'(1) : '0;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [MANT_WIDTH-1:0] x;
        always_comb x = vec_q[(int'(next_beat) * LANES + l) * MANT_WIDTH +: MANT_WIDTH];
        subtractor_lane #(
            .MANT_WIDTH(MANT_WIDTH),
            .EXP_WIDTH (EXP_WIDTH),
            .SATURATE  (SATURATE)
        ) u_lane (
            .x     (x),
            .s     (sum_q),
            .result(lane_data[l*EXP_WIDTH +: EXP_WIDTH]),
            .sat   (lane_sat[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec_q     <= '0;
            sum_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
            out_beat  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        vec_q <= input_bus;
                        sum_q <= exp_sum;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_taken) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (advance) begin
                        out_valid <= 1'b1;
                        out_data  <= lane_data;
                        out_sat   <= lane_sat;
                        out_beat  <= next_beat;
                        out_last  <= (next_beat == LAST_BEAT);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subtractors_pipe.sv
// tb/tb_subtractors_pipe.sv - scoreboard bench for subtractors_pipe over three parameter sets
module tb_subtractors_pipe;

    typedef struct {
        logic [89:0] data;
        logic [9:0]  sat;
        int          beat;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv;
    logic [2:0]  ir;
    logic [8:0]  exp_sum;
    logic [79:0] bus;
    logic        out_ready;

    logic        ov0, ov1, ov2;
    logic [17:0] od0, od1;
    logic [89:0] od2;
    logic [1:0]  os0, os1;
    logic [9:0]  os2;
    logic [2:0]  ob0, ob1;
    logic [0:0]  ob2;
    logic        ol0, ol1, ol2;

    int   checks = 0;
    int   errors = 0;
    exp_t q[3][$];
    int   cur_x[10];
    int   cur_s;
    int   lanes_of[3] = '{2, 2, 10};
    bit   sat_of[3]   = '{1'b1, 1'b0, 1'b1};
    bit   rnd_done;

    always #5 clk = ~clk;

    subtractors_pipe #(.LANES(2), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .exp_sum(exp_sum), .input_bus(bus),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(os0), .out_beat(ob0), .out_last(ol0));
    subtractors_pipe #(.LANES(2), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .exp_sum(exp_sum), .input_bus(bus),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1), .out_beat(ob1), .out_last(ol1));
    subtractors_pipe #(.LANES(10), .SATURATE(1)) dut_one (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .exp_sum(exp_sum), .input_bus(bus),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_sat(os2), .out_beat(ob2), .out_last(ol2));

    task automatic expect_eq(input string name, input logic [95:0] act, input logic [95:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, want);
        end
    endtask

    // Reference: plain integer subtraction, clamped to the signed 9-bit range when saturating.
    function automatic exp_t model_beat(input int lanes, input int beat, input bit sat_en);
        exp_t e;
        int   d;
        e.data = '0;
        e.sat  = '0;
        for (int l = 0; l < lanes; l++) begin
            d = cur_x[beat * lanes + l] - cur_s;
            if (sat_en && d > 255) begin
                d = 255;
                e.sat[l] = 1'b1;
            end else if (sat_en && d < -256) begin
                d = -256;
                e.sat[l] = 1'b1;
            end
            e.data[l*9 +: 9] = d[8:0];
        end
        e.beat = beat;
        e.last = (beat == 10 / lanes - 1);
        return e;
    endfunction

    task automatic send(input int d, input bit hold);
        int n = 0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) bus[i*8 +: 8] = 8'(cur_x[i]);
        exp_sum = 9'(cur_s);
        iv[d]   = 1'b1;
        while (!ir[d]) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                expect_eq("capture_timeout", 96'(0), 96'(1));
                iv[d] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        for (int b = 0; b < 10 / lanes_of[d]; b++) q[d].push_back(model_beat(lanes_of[d], b, sat_of[d]));
        if (!hold) begin
            @(negedge clk);
            iv[d] = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        expect_eq("drain", 96'(q[0].size() + q[1].size() + q[2].size()), 96'(0));
    endtask

    task automatic wait_beat0(input int beat);
        int n = 0;
        @(negedge clk);
        while (!(ov0 && int'(ob0) == beat) && n < 100) begin
            @(negedge clk);
            n++;
        end
        expect_eq("wait_beat", 96'(n < 100), 96'(1));
    endtask

    task automatic mon_check(input int d, input logic [89:0] data, input logic [9:0] sat,
                             input int beat, input bit last, input bit rdy_now);
        exp_t e;
        checks++;
        if (q[d].size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat dut%0d actual beat=%0d data=%h required none", d, beat, data);
        end else begin
            e = q[d][0];
            if (data !== e.data || sat !== e.sat || beat != e.beat || last !== e.last) begin
                errors++;
                $display("FAIL beat dut%0d actual data=%h sat=%h beat=%0d last=%0d required data=%h sat=%h beat=%0d last=%0d",
                         d, data, sat, beat, last, e.data, e.sat, e.beat, e.last);
            end
            if (out_ready) void'(q[d].pop_front());
        end
        expect_eq("in_ready_busy", 96'(rdy_now), 96'(0));
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (ov0) mon_check(0, 90'(od0), 10'(os0), int'(ob0), ol0, ir[0]);
            if (ov1) mon_check(1, 90'(od1), 10'(os1), int'(ob1), ol1, ir[1]);
            if (ov2) mon_check(2, od2, os2, int'(ob2), ol2, ir[2]);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        iv        = '0;
        exp_sum   = '0;
        bus       = '0;
        out_ready = 1'b1;
        rnd_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_in_ready", 96'(ir), 96'(0));
        expect_eq("rst_out_valid", 96'({ov0, ov1, ov2}), 96'(0));
        expect_eq("rst_out_data", 96'(od0), 96'(0));
        expect_eq("rst_out_sat", 96'(os0), 96'(0));
        expect_eq("rst_out_beat", 96'(ob0), 96'(0));
        expect_eq("rst_out_last", 96'({ol0, ol1, ol2}), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_eq("in_ready_after_rst", 96'(ir), 96'(7));

        // ramp against exp_sum=200
        for (int i = 0; i < 10; i++) cur_x[i] = i * 10;
        cur_s = 200;
        send(0, 1'b0);
        drain();

        // clamp vs wrap of 0 - 511
        for (int i = 0; i < 10; i++) cur_x[i] = int'($urandom_range(0, 255));
        cur_x[0] = 0;
        cur_s    = 511;
        send(0, 1'b0);
        send(1, 1'b0);
        drain();

        // backpressure on beat 2
        for (int i = 0; i < 10; i++) cur_x[i] = i * 10;
        cur_s = 200;
        send(0, 1'b0);
        wait_beat0(2);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        drain();

        // in_valid held across two vectors
        for (int i = 0; i < 10; i++) cur_x[i] = 25 * i;
        cur_s = 100;
        send(0, 1'b1);
        for (int i = 0; i < 10; i++) cur_x[i] = 255 - i;
        cur_s = 3;
        send(0, 1'b0);
        drain();

        // reset in the middle of a vector
        for (int i = 0; i < 10; i++) cur_x[i] = i + 1;
        cur_s = 7;
        send(0, 1'b0);
        wait_beat0(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("midrst_out_valid", 96'(ov0), 96'(0));
        expect_eq("midrst_in_ready", 96'(ir[0]), 96'(0));
        expect_eq("midrst_out_beat", 96'(ob0), 96'(0));
        q[0].delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_eq("post_rst_in_ready", 96'(ir[0]), 96'(1));
        send(0, 1'b0);
        drain();

        // single-beat configuration
        for (int i = 0; i < 10; i++) cur_x[i] = 255;
        cur_s = 0;
        send(2, 1'b0);
        drain();

        // random vectors to all three instances under random backpressure
        fork
            begin
                for (int v = 0; v < 30; v++) begin
                    for (int i = 0; i < 10; i++)
                        cur_x[i] = ($urandom_range(0, 3) == 0) ? 255 * int'($urandom_range(0, 1))
                                                               : int'($urandom_range(0, 255));
                    cur_s = ($urandom_range(0, 3) == 0) ? 511 * int'($urandom_range(0, 1))
                                                        : int'($urandom_range(0, 511));
                    send(int'($urandom_range(0, 2)), 1'b0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
